// File: rtl/zoom_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : zoom_frame_loader_if
// Description : Raster pixel stream handshake (valid/ready, sof, eol, data).
// Revision    : 1.0 - initial release
// ============================================================================
interface zoom_frame_loader_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_sof;
    logic       s_eol;

    modport master (output s_valid, s_data, s_sof, s_eol, input s_ready);
    modport slave  (input s_valid, s_data, s_sof, s_eol, output s_ready);
endinterface
`default_nettype wire

// File: rtl/zoom_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : zoom_frame_loader
// Description : Loads a raster pixel stream into the zoom input frame memory
//               and holds the completed frame until the zoom stage acks it.
// Revision    : 1.0 - initial release
// ============================================================================
module zoom_frame_loader #(
    parameter int LARGURA = 2,
    parameter int ALTURA  = 2,
    parameter int ADDR_W  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    zoom_frame_loader_if.slave     s,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [7:0]             wr_data,
    output logic                   frame_valid,
    input  wire logic              frame_ack,
    output logic                   err_sof,
    output logic                   err_eol,
    output logic [7:0]             frame_count
);

    localparam int c_XW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam int c_YW = (ALTURA  > 1) ? $clog2(ALTURA)  : 1;
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(LARGURA - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(ALTURA - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_XW-1:0]     r_x;
    logic [c_YW-1:0]     r_y;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;
    logic                r_frame_valid;
    logic                r_err_sof;
    logic                r_err_eol;
    logic [7:0]          r_frame_count;

    state_t              w_state_nxt;
    logic [c_XW-1:0]     w_x_nxt;
    logic [c_YW-1:0]     w_y_nxt;
    logic [c_XW-1:0]     w_px;
    logic [c_YW-1:0]     w_py;
    logic                w_ready;
    logic                w_accept;
    logic                w_step;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_err_sof;
    logic                w_err_eol;
    logic                w_frame_done;
    logic                w_x_last;

    assign w_ready   = (r_state != ST_FULL);
    assign w_accept  = s.s_valid & w_ready;
    assign s.s_ready = w_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_px         = r_x;
        w_py         = r_y;
        w_step       = 1'b0;
        w_wr         = 1'b0;
        w_addr       = '0;
        w_err_sof    = 1'b0;
        w_err_eol    = 1'b0;
        w_frame_done = 1'b0;
        w_x_last     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A frame opens as an ordinary pixel at (0,0), so eol still counts here
                if (w_accept && s.s_sof) begin
                    w_px        = '0;
                    w_py        = '0;
                    w_step      = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (s.s_sof) begin
                        w_wr      = 1'b1;
                        w_addr    = '0;
                        w_x_nxt   = c_XW'(1);
                        w_y_nxt   = '0;
                        w_err_sof = 1'b1;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (frame_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_x_nxt     = '0;
                w_y_nxt     = '0;
            end
        endcase

        if (w_step) begin
            w_wr      = 1'b1;
            w_addr    = ADDR_W'(32'(w_py) * 32'(LARGURA) + 32'(w_px));
            w_x_last  = (w_px == c_X_LAST);
            // Error when eol disagrees with the pixel count, in either direction
            w_err_eol = w_x_last ^ s.s_eol;
            if (w_x_last || s.s_eol) begin
                w_x_nxt = '0;
                if (w_py == c_Y_LAST) begin
                    w_y_nxt      = '0;
                    w_frame_done = 1'b1;
                    w_state_nxt  = ST_FULL;
                end else begin
                    w_y_nxt = w_py + c_YW'(1);
                end
            end else begin
                w_x_nxt = w_px + c_XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_valid <= 1'b0;
            r_err_sof     <= 1'b0;
            r_err_eol     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_wr_en   <= w_wr;
            r_err_sof <= w_err_sof;
            r_err_eol <= w_err_eol;
            if (w_wr) begin
                r_wr_addr <= w_addr;
                r_wr_data <= s.s_data;
            end
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            // Lags the state by one cycle so it rises only after the final write lands
            r_frame_valid <= (r_state == ST_FULL) && !frame_ack;
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_valid = r_frame_valid;
    assign err_sof     = r_err_sof;
    assign err_eol     = r_err_eol;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_zoom_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_zoom_frame_loader
// Description : Self-checking bench for zoom_frame_loader (2x2 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zoom_frame_loader;

    localparam int L      = 2;
    localparam int A      = 2;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_ack = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_valid;
    logic              err_sof;
    logic              err_eol;
    logic [7:0]        frame_count;

    zoom_frame_loader_if sif ();

    zoom_frame_loader #(.LARGURA(L), .ALTURA(A), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (sif),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .err_sof     (err_sof),
        .err_eol     (err_eol),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed activity, collected away from the active edge
    logic [ADDR_W+7:0] obs_wr[$];
    int obs_sof = 0;
    int obs_eol = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) obs_wr.push_back({wr_addr, wr_data});
        if (err_sof === 1'b1) obs_sof++;
        if (err_eol === 1'b1) obs_eol++;
    end

    // Reference model: frame position as plain integers
    logic [ADDR_W+7:0] exp_wr[$];
    int exp_sof = 0;
    int exp_eol = 0;
    int m_frames = 0;
    bit m_active = 0;
    bit m_full = 0;
    int m_px = 0;
    int m_py = 0;

    task automatic model_beat(input logic [7:0] d, input bit sof, input bit eol);
        if (m_full) return;
        if (m_active && sof) begin
            exp_wr.push_back({ADDR_W'(0), d});
            exp_sof++;
            m_px = 1;
            m_py = 0;
            return;
        end
        if (!m_active && !sof) return;
        if (!m_active) begin
            m_active = 1;
            m_px = 0;
            m_py = 0;
        end
        exp_wr.push_back({ADDR_W'(m_py * L + m_px), d});
        if ((m_px == L - 1) != eol) exp_eol++;
        if (m_px == L - 1 || eol) begin
            m_px = 0;
            m_py++;
            if (m_py == A) begin
                m_active = 0;
                m_full = 1;
                m_frames++;
            end
        end else begin
            m_px++;
        end
    endtask

    // Drives one beat from a negedge; returns at the following negedge
    task automatic beat(input logic [7:0] d, input bit sof, input bit eol);
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_sof   = sof;
        sif.s_eol   = eol;
        model_beat(d, sof, eol);
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_sof   = 1'b0;
        sif.s_eol   = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        m_full = 0;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        sif.s_valid = 1'b0;
        sif.s_data  = 8'd0;
        sif.s_sof   = 1'b0;
        sif.s_eol   = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_en, wr_addr, wr_data, frame_valid, err_sof, err_eol, frame_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%0d fv=%b es=%b ee=%b fc=%0d, expected all 0",
                     wr_en, wr_addr, wr_data, frame_valid, err_sof, err_eol, frame_count);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sif.s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b, expected 1", sif.s_ready);
        end
    endtask

    task automatic test_normal();
        logic [ADDR_W+7:0] lit [4];
        int base;
        lit = '{{2'd0, 8'd1}, {2'd1, 8'd2}, {2'd2, 8'd3}, {2'd3, 8'd4}};
        base = exp_wr.size();
        beat(8'd1, 1, 0);
        beat(8'd2, 0, 1);
        beat(8'd3, 0, 0);
        beat(8'd4, 0, 1);
        n_cmp++;
        if (sif.s_ready !== 1'b0 || frame_valid !== 1'b0 || frame_count !== 8'(m_frames)) begin
            n_bad++;
            $display("FAIL normal_t1: got ready=%b fv=%b fc=%0d, expected ready=0 fv=0 fc=%0d",
                     sif.s_ready, frame_valid, frame_count, m_frames);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL normal_fv_t2: got %b, expected 1", frame_valid);
        end
        n_cmp++;
        if (obs_wr.size() != base + 4) begin
            n_bad++;
            $display("FAIL normal_wr_count: got %0d, expected %0d", obs_wr.size(), base + 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs_wr[base+i] !== lit[i] || exp_wr[base+i] !== lit[i]) begin
                    n_bad++;
                    $display("FAIL normal_wr[%0d]: got %h, expected %h", i, obs_wr[base+i], lit[i]);
                end
            end
        end
        ack();
        n_cmp++;
        if (frame_valid !== 1'b0 || sif.s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL normal_ack: got fv=%b ready=%b, expected fv=0 ready=1", frame_valid, sif.s_ready);
        end
    endtask

    task automatic test_scenario(input string name, input logic [7:0] d [], input bit sof [], input bit eol []);
        int base;
        base = exp_wr.size();
        foreach (d[i]) beat(d[i], sof[i], eol[i]);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_bad++;
            $display("FAIL %s_wr_count: got %0d, expected %0d", name, obs_wr.size(), exp_wr.size());
        end else begin
            for (int i = base; i < exp_wr.size(); i++) begin
                n_cmp++;
                if (obs_wr[i] !== exp_wr[i]) begin
                    n_bad++;
                    $display("FAIL %s_wr[%0d]: got %h, expected %h", name, i - base, obs_wr[i], exp_wr[i]);
                end
            end
        end
        n_cmp++;
        if (obs_sof != exp_sof || obs_eol != exp_eol || frame_valid !== m_full || frame_count !== 8'(m_frames)) begin
            n_bad++;
            $display("FAIL %s_status: got sof=%0d eol=%0d fv=%b fc=%0d, expected sof=%0d eol=%0d fv=%b fc=%0d",
                     name, obs_sof, obs_eol, frame_valid, frame_count, exp_sof, exp_eol, m_full, m_frames);
        end
        if (m_full) ack();
    endtask

    task automatic test_junk();
        test_scenario("junk", '{8'd9, 8'd9, 8'd1, 8'd2, 8'd3, 8'd4}, '{0, 0, 1, 0, 0, 0}, '{0, 0, 0, 1, 0, 1});
    endtask

    task automatic test_mid_sof();
        int s0;
        s0 = obs_sof;
        test_scenario("mid_sof", '{8'd1, 8'd2, 8'd7, 8'd8, 8'd5, 8'd6}, '{1, 0, 1, 0, 0, 0}, '{0, 1, 0, 1, 0, 1});
        n_cmp++;
        if (obs_sof - s0 != 1) begin
            n_bad++;
            $display("FAIL mid_sof_pulses: got %0d, expected 1", obs_sof - s0);
        end
    endtask

    task automatic test_eol_errors();
        int e0;
        e0 = obs_eol;
        test_scenario("eol_missing", '{8'd1, 8'd2, 8'd3, 8'd4}, '{1, 0, 0, 0}, '{0, 0, 0, 1});
        test_scenario("eol_early", '{8'd1, 8'd3, 8'd4}, '{1, 0, 0}, '{1, 0, 1});
        n_cmp++;
        if (obs_eol - e0 != 2) begin
            n_bad++;
            $display("FAIL eol_pulses: got %0d, expected 2", obs_eol - e0);
        end
    endtask

    task automatic test_back_pressure();
        int base;
        beat(8'd1, 1, 0);
        beat(8'd2, 0, 1);
        beat(8'd3, 0, 0);
        beat(8'd4, 0, 1);
        @(negedge clk);
        base = obs_wr.size();
        for (int i = 0; i < 20; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = 8'($urandom);
            sif.s_sof   = 1'($urandom);
            n_cmp++;
            if (sif.s_ready !== 1'b0 || wr_en !== 1'b0 || frame_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL backpressure[%0d]: got ready=%b wr_en=%b fv=%b, expected 0 0 1",
                         i, sif.s_ready, wr_en, frame_valid);
            end
            @(negedge clk);
        end
        sif.s_valid = 1'b0;
        sif.s_sof   = 1'b0;
        n_cmp++;
        if (obs_wr.size() != base) begin
            n_bad++;
            $display("FAIL backpressure_writes: got %0d, expected 0", obs_wr.size() - base);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int base;
        beat(8'd1, 1, 0);
        beat(8'd2, 0, 1);
        beat(8'd3, 0, 0);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({wr_en, wr_addr, wr_data, frame_valid, err_sof, err_eol, frame_count} !== '0 || sif.s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got en=%b addr=%0d data=%0d fv=%b fc=%0d ready=%b, expected zeros ready=1",
                     wr_en, wr_addr, wr_data, frame_valid, frame_count, sif.s_ready);
        end
        m_active = 0;
        m_full = 0;
        m_frames = 0;
        @(negedge clk);
        rst = 1'b1;
        base = exp_wr.size();
        test_scenario("after_reset", '{8'd5, 8'd6, 8'd7, 8'd8}, '{1, 0, 0, 0}, '{0, 1, 0, 1});
        n_cmp++;
        if (exp_wr[base] !== {2'd0, 8'd5} || obs_wr[base] !== {2'd0, 8'd5}) begin
            n_bad++;
            $display("FAIL after_reset_first: got %h, expected %h", obs_wr[base], {2'd0, 8'd5});
        end
    endtask

    task automatic test_random();
        int base;
        int fc;
        bit v, so, eo;
        base = exp_wr.size();
        fc = 0;
        for (int c = 0; c < 600; c++) begin
            frame_ack = 1'b0;
            if (m_full) begin
                fc++;
                n_cmp++;
                if (sif.s_ready !== 1'b0 || (fc >= 2 && frame_valid !== 1'b1)) begin
                    n_bad++;
                    $display("FAIL random_full[%0d]: got ready=%b fv=%b, expected ready=0 fv=%b",
                             c, sif.s_ready, frame_valid, fc >= 2);
                end
                sif.s_valid = 1'($urandom);
                sif.s_sof = 1'($urandom);
                if (fc >= 2 && $urandom_range(0, 2) == 0) begin
                    frame_ack = 1'b1;
                    m_full = 0;
                end
            end else begin
                fc = 0;
                n_cmp++;
                if (sif.s_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL random_ready[%0d]: got %b, expected 1", c, sif.s_ready);
                end
                v  = ($urandom_range(0, 3) != 0);
                so = m_active ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
                eo = (m_px == L - 1) ^ ($urandom_range(0, 7) == 0);
                sif.s_valid = v;
                sif.s_data  = 8'($urandom);
                sif.s_sof   = so;
                sif.s_eol   = eo;
                if (v) model_beat(sif.s_data, so, eo);
            end
            @(negedge clk);
        end
        frame_ack = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_sof = 1'b0;
        sif.s_eol = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_bad++;
            $display("FAIL random_wr_count: got %0d, expected %0d", obs_wr.size(), exp_wr.size());
        end else begin
            for (int i = base; i < exp_wr.size(); i++) begin
                n_cmp++;
                if (obs_wr[i] !== exp_wr[i]) begin
                    n_bad++;
                    $display("FAIL random_wr[%0d]: got %h, expected %h", i - base, obs_wr[i], exp_wr[i]);
                end
            end
        end
        n_cmp++;
        if (obs_sof != exp_sof || obs_eol != exp_eol || frame_count !== 8'(m_frames)) begin
            n_bad++;
            $display("FAIL random_status: got sof=%0d eol=%0d fc=%0d, expected sof=%0d eol=%0d fc=%0d",
                     obs_sof, obs_eol, frame_count, exp_sof, exp_eol, 8'(m_frames));
        end
        if (m_full) ack();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_junk();
        test_mid_sof();
        test_eol_errors();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
